// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display scheduler.
package seg7_pkg;

  localparam int DIG_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_disp_sched_if.sv
// Requester-side bus and display-register outputs of the scheduler.
interface seg7_disp_sched_if
  import seg7_pkg::*;
#(
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]       iREQ;
  logic [DIG_W*NREQ-1:0] iDATA;
  logic                  iPRI_EN;
  logic [DIG_W-1:0]      oDIG;
  logic                  oWR;
  logic [NREQ-1:0]       oGNT;
  logic                  oSWITCH;

  modport master (
    output iREQ, iDATA, iPRI_EN,
    input  oDIG, oWR, oGNT, oSWITCH
  );

  modport slave (
    input  iREQ, iDATA, iPRI_EN,
    output oDIG, oWR, oGNT, oSWITCH
  );

endinterface

// File: rtl/seg7_rr_pick.sv
// Combinational round-robin picker: first active request after the last grant.
module seg7_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx,
  output logic            o_valid
);

  logic [PW-1:0] w_cand;

  // The last-granted requester is visited last, so it only wins when alone.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_cand = PW'((int'(i_ptr) + i) % NREQ);
      if (!o_valid && i_req[w_cand]) begin
        o_valid       = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_disp_sched.sv
// Time-shares the 4-digit display register among NREQ requesters with
// round-robin dwell grants and optional preemption by requester 0.
module seg7_disp_sched
  import seg7_pkg::*;
#(
  parameter int              NREQ      = 4,
  parameter int              DWELL_CYC = 25000000,
  parameter int              DWELL_W   = 25,
  parameter logic [DIG_W-1:0] BLANK_VAL = 16'h0000
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  seg7_disp_sched_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              r_state, w_stateNext;
  logic [PW-1:0]       r_ptr, w_ptrNext;
  logic [DWELL_W-1:0]  r_cnt, w_cntNext, w_cntDec;
  logic [NREQ-1:0]     r_gnt, w_gntNext;
  logic [DIG_W-1:0]    r_dig, w_digNext;
  logic                r_wr, w_wrNext;
  logic                r_sw, w_swNext;

  logic [DIG_W-1:0]    w_data [NREQ];
  logic [NREQ-1:0]     w_pickGnt;
  logic [PW-1:0]       w_pickIdx;
  logic                w_pickValid;
  logic                w_pre;
  logic                w_curReq;
  logic                w_doGrant;
  logic                w_toIdle;
  logic [PW-1:0]       w_grantIdx;
  logic [NREQ-1:0]     w_grantVec;

  for (genvar g = 0; g < NREQ; g++) begin : g_data
    assign w_data[g] = bus.iDATA[DIG_W*g +: DIG_W];
  end

  seg7_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_req   (bus.iREQ),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pickGnt),
    .o_idx   (w_pickIdx),
    .o_valid (w_pickValid)
  );

  assign w_pre    = bus.iPRI_EN && bus.iREQ[0] && !((r_state == SHOW) && r_gnt[0]);
  assign w_curReq = bus.iREQ[r_ptr];
  assign w_cntDec = (r_cnt == '0) ? '0 : r_cnt - DWELL_W'(1);

  // Preemption overrides every other grant decision in either state.
  always_comb begin
    w_stateNext = r_state;
    w_ptrNext   = r_ptr;
    w_cntNext   = w_cntDec;
    w_gntNext   = r_gnt;
    w_digNext   = r_dig;
    w_wrNext    = r_wr;
    w_swNext    = 1'b0;
    w_doGrant   = 1'b0;
    w_toIdle    = 1'b0;
    w_grantIdx  = w_pickIdx;
    w_grantVec  = w_pickGnt;

    if (w_pre) begin
      w_doGrant  = 1'b1;
      w_grantIdx = '0;
      w_grantVec = NREQ'(1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pickValid) w_doGrant = 1'b1;
        end
        SHOW: begin
          if (!w_curReq) begin
            if (w_pickValid) w_doGrant = 1'b1;
            else             w_toIdle  = 1'b1;
          end else if ((r_cnt == '0) && (w_pickIdx != r_ptr)) begin
            w_doGrant = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (w_doGrant) begin
      w_stateNext = SHOW;
      w_ptrNext   = w_grantIdx;
      w_cntNext   = DWELL_W'(DWELL_CYC - 1);
      w_gntNext   = w_grantVec;
      w_digNext   = w_data[w_grantIdx];
      w_wrNext    = 1'b1;
      w_swNext    = 1'b1;
    end else if (w_toIdle) begin
      w_stateNext = IDLE;
      w_gntNext   = '0;
      w_digNext   = BLANK_VAL;
      w_wrNext    = 1'b1;
      w_swNext    = 1'b1;
    end else if (r_state == SHOW) begin
      w_digNext   = w_data[r_ptr];
      w_wrNext    = 1'b1;
    end else begin
      w_gntNext   = '0;
      w_digNext   = BLANK_VAL;
      w_wrNext    = 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= IDLE;
      r_ptr   <= PW'(NREQ - 1);
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_dig   <= BLANK_VAL;
      r_wr    <= 1'b0;
      r_sw    <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_ptr   <= w_ptrNext;
      r_cnt   <= w_cntNext;
      r_gnt   <= w_gntNext;
      r_dig   <= w_digNext;
      r_wr    <= w_wrNext;
      r_sw    <= w_swNext;
    end
  end

  assign bus.oDIG    = r_dig;
  assign bus.oWR     = r_wr;
  assign bus.oGNT    = r_gnt;
  assign bus.oSWITCH = r_sw;

endmodule
